// File: rtl/top_v1_if.sv
`timescale 1ns/1ps
// Host-side strobe and address group of the top_v1 arithmetic peripheral.
// The 8-bit data bus stays a plain inout on top_v1 so the tristate resolves at the pin.
interface top_v1_if;
   logic       readBus;     // active-low read strobe
   logic       writeBus;    // active-low write strobe
   logic [2:0] addressBus;  // register address

   modport master (output readBus, writeBus, addressBus);
   modport slave  (input  readBus, writeBus, addressBus);
endinterface

// File: rtl/top_v1.sv
`timescale 1ns/1ps
// top_v1: host-mapped signed arithmetic unit (MULT, DIVMOD, DIVFRACT, SQRT).
// Operands A/B are written bytewise, an opcode write launches an iterative
// one-bit-per-cycle engine, and the 32-bit result X is read back bytewise.
module top_v1 (
   input  logic       clk,
   input  logic       reset,
   top_v1_if.slave    hostIf,
   inout  wire  [7:0] dataBus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   localparam logic [1:0] OP_MULT     = 2'd0;
   localparam logic [1:0] OP_DIVMOD   = 2'd1;
   localparam logic [1:0] OP_DIVFRACT = 2'd2;
   localparam logic [1:0] OP_SQRT     = 2'd3;

   // Architectural registers, referenced by name from verification.
   logic [15:0] A, B;
   logic [31:0] X;
   logic        errReg;

   stateT       state, nextState;
   logic        wrCur, wrPrev;
   logic [2:0]  addrCap;
   logic [7:0]  dataCap;
   logic        wrEvent, opWrite;
   logic        busy, launch, step, loadX;

   // Engine state: shReg shifts operand bits out of its MSB end, accReg
   // collects product / quotient / root bits, remReg holds the partial remainder.
   logic [1:0]  opReg;
   logic        negRes, negRem;
   logic [15:0] magB;
   logic [4:0]  cnt;
   logic [31:0] shReg, accReg;
   logic [17:0] remReg;

   logic [15:0] magA, magBIn;
   logic        launchErr;
   logic [16:0] divShift, divDiff;
   logic        divTake;
   logic [19:0] sqShift, sqTrial;
   logic [17:0] sqDiff;
   logic        sqTake;
   logic [31:0] mulNext, resultVal;
   logic [15:0] quo, rem;
   logic [7:0]  readData;

   // Sample strobe, address and data every edge; a write is a 0->1 strobe step.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: history resets to the idle-high level so a strobe already high after reset is not seen as a rising edge.
         wrCur   <= 1'b1;
         wrPrev  <= 1'b1;
         addrCap <= '0;
         dataCap <= '0;
      end else begin
         // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
         wrCur   <= hostIf.writeBus;
         wrPrev  <= wrCur;
         addrCap <= hostIf.addressBus;
         dataCap <= dataBus;
      end
   end

   assign wrEvent = wrCur & ~wrPrev;
   assign opWrite = wrEvent && (addrCap == 3'd7);

   // Operand byte writes; accepted even while an operation is running.
   always_ff @(posedge clk) begin
      if (reset) begin
         A <= '0;
         B <= '0;
      end else if (wrEvent) begin
         case (addrCap)
            3'd0:    A[15:8] <= dataCap;
            3'd1:    A[7:0]  <= dataCap;
            3'd2:    B[15:8] <= dataCap;
            3'd3:    B[7:0]  <= dataCap;
            default: ;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // FSM next state: RUN lasts until the iteration counter expires.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      nextState = state;
      case (state)
         IDLE:    if (opWrite) nextState = RUN;
         RUN:     if (cnt == 5'd0) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // FSM outputs; an opcode write outside IDLE is simply not launched.
   always_comb begin
      busy   = (state != IDLE);
      launch = (state == IDLE) && opWrite;
      step   = (state == RUN);
      loadX  = (state == DONE);
   end

   assign magA   = A[15] ? (16'd0 - A) : A;
   assign magBIn = B[15] ? (16'd0 - B) : B;

   // Operand faults detected at launch; the engine still runs but X is forced to 0.
   always_comb begin
      case (dataCap[1:0])
         OP_MULT: launchErr = (A == 16'h8000) || (B == 16'h8000);
         OP_SQRT: launchErr = A[15];
         default: launchErr = (B == 16'h0000);
      endcase
   end

   // One iteration of each algorithm: shift/add multiply, restoring divide, restoring sqrt.
   always_comb begin
      divShift = {remReg[15:0], shReg[31]};
      divTake  = divShift >= {1'b0, magB};
      divDiff  = divShift - {1'b0, magB};
      sqShift  = {remReg, shReg[31:30]};
      sqTrial  = {2'b00, accReg[15:0], 2'b01};
      sqTake   = sqShift >= sqTrial;
      sqDiff   = sqShift[17:0] - sqTrial[17:0];
      mulNext  = {accReg[30:0], 1'b0} + (shReg[31] ? {16'h0000, magB} : 32'h0);
   end

   // Apply signs to the unsigned engine result and format it per opcode.
   always_comb begin
      quo = negRes ? (16'd0 - accReg[15:0]) : accReg[15:0];
      rem = negRem ? (16'd0 - remReg[15:0]) : remReg[15:0];
      case (opReg)
         OP_DIVMOD: resultVal = {quo, rem};
         OP_SQRT:   resultVal = {8'h00, accReg[15:0], 8'h00};
         default:   resultVal = negRes ? (32'd0 - accReg) : accReg;
      endcase
      if (errReg) resultVal = 32'h0;
   end

   // Engine datapath: latch magnitudes on launch, iterate in RUN, publish X in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         X      <= '0;
         errReg <= 1'b0;
         opReg  <= OP_MULT;
         negRes <= 1'b0;
         negRem <= 1'b0;
         magB   <= '0;
         cnt    <= '0;
         shReg  <= '0;
         accReg <= '0;
         remReg <= '0;
      end else if (launch) begin
         opReg  <= dataCap[1:0];
         negRes <= A[15] ^ B[15];
         negRem <= A[15];
         magB   <= magBIn;
         shReg  <= (dataCap[1:0] == OP_DIVMOD) ? {16'h0000, magA} : {magA, 16'h0000};
         accReg <= '0;
         remReg <= '0;
         cnt    <= (dataCap[1:0] == OP_DIVMOD || dataCap[1:0] == OP_DIVFRACT) ? 5'd31 : 5'd15;
         errReg <= launchErr;
      end else if (step) begin
         cnt <= cnt - 5'd1;
         case (opReg)
            OP_MULT: begin
               accReg <= mulNext;
               shReg  <= {shReg[30:0], 1'b0};
            end
            OP_SQRT: begin
               remReg <= sqTake ? sqDiff : sqShift[17:0];
               accReg <= {accReg[30:0], sqTake};
               shReg  <= {shReg[29:0], 2'b00};
            end
            default: begin
               remReg <= {1'b0, (divTake ? divDiff : divShift)};
               accReg <= {accReg[30:0], divTake};
               shReg  <= {shReg[30:0], 1'b0};
            end
         endcase
      end else if (loadX) begin
         X <= resultVal;
      end
   end

   // Combinational read mux; the bus is only driven while the read strobe is low.
   always_comb begin
      readData = 8'h00;
      case (hostIf.addressBus)
         3'd0:    readData = X[31:24];
         3'd1:    readData = X[23:16];
         3'd2:    readData = X[15:8];
         3'd3:    readData = X[7:0];
         3'd4:    readData = {6'b000000, errReg, busy};
         default: ;
      endcase
   end

   assign dataBus = hostIf.readBus ? 8'hzz : readData;
endmodule

// File: tb/tb_top_v1.sv
`timescale 1ns/1ps
// Self-checking bench for top_v1: directed vectors plus randomized operations
// compared against an arithmetic reference model.
module tb_top_v1;
   logic       clk = 1'b0;
   logic       reset;
   logic       hostDrive;
   logic [7:0] hostData;
   wire  [7:0] dataBus;

   top_v1_if hostIf();

   assign dataBus = hostDrive ? hostData : 8'hzz;

   top_v1 dut (
      .clk     (clk),
      .reset   (reset),
      .hostIf  (hostIf),
      .dataBus (dataBus)
   );

   always #1 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] x;
      logic        err;
   } vecT;

   vecT vecs [20] = '{
      '{2'd0, 16'h8001, 16'h8001, 32'h3FFF0001, 1'b0},
      '{2'd0, 16'hFFF0, 16'hFFFF, 32'h00000010, 1'b0},
      '{2'd0, 16'h0001, 16'hFFFF, 32'hFFFFFFFF, 1'b0},
      '{2'd0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0},
      '{2'd0, 16'h8000, 16'h8000, 32'h00000000, 1'b1},
      '{2'd0, 16'h7FFF, 16'h0000, 32'h00000000, 1'b0},
      '{2'd1, 16'hFD00, 16'hFF00, 32'h00030000, 1'b0},
      '{2'd1, 16'hFFF0, 16'h0003, 32'hFFFBFFFF, 1'b0},
      '{2'd1, 16'h7FFE, 16'h7FFF, 32'h00007FFE, 1'b0},
      '{2'd1, 16'h0001, 16'h0000, 32'h00000000, 1'b1},
      '{2'd2, 16'h7FFF, 16'h0003, 32'h2AAA5555, 1'b0},
      '{2'd2, 16'h0003, 16'h0002, 32'h00018000, 1'b0},
      '{2'd2, 16'h000A, 16'h0003, 32'h00035555, 1'b0},
      '{2'd2, 16'h0001, 16'h0004, 32'h00004000, 1'b0},
      '{2'd2, 16'h0005, 16'h0000, 32'h00000000, 1'b1},
      '{2'd3, 16'h0004, 16'h1234, 32'h00020000, 1'b0},
      '{2'd3, 16'h0064, 16'h0000, 32'h000A0000, 1'b0},
      '{2'd3, 16'h0002, 16'hFFFF, 32'h00016A00, 1'b0},
      '{2'd3, 16'h7FFF, 16'h0001, 32'h00B50400, 1'b0},
      '{2'd3, 16'hFFFF, 16'h0001, 32'h00000000, 1'b1}
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change half a nanosecond after the rising edge.
   task automatic waitDrive();
      @(posedge clk);
      #0.5;
   endtask

   task automatic hostWrite(input logic [2:0] addr, input logic [7:0] data);
      waitDrive();
      hostIf.addressBus = addr;
      hostData          = data;
      hostDrive         = 1'b1;
      hostIf.writeBus   = 1'b0;
      waitDrive();
      hostIf.writeBus   = 1'b1;
      waitDrive();
      hostDrive         = 1'b0;
   endtask

   task automatic hostRead(input logic [2:0] addr, output logic [7:0] data);
      waitDrive();
      hostIf.addressBus = addr;
      hostIf.readBus    = 1'b0;
      #1;
      data              = dataBus;
      hostIf.readBus    = 1'b1;
   endtask

   // Reference: {error, X} from plain integer arithmetic on the signed operands.
   function automatic logic [32:0] refModel(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      longint sa, sb, q, r, v, root;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: begin
            if (a == 16'h8000 || b == 16'h8000) return {1'b1, 32'h0};
            q = sa * sb;
            return {1'b0, q[31:0]};
         end
         2'd1: begin
            if (sb == 0) return {1'b1, 32'h0};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, q[15:0], r[15:0]};
         end
         2'd2: begin
            if (sb == 0) return {1'b1, 32'h0};
            q = ((sa < 0 ? -sa : sa) * 65536) / (sb < 0 ? -sb : sb);
            if ((sa < 0) != (sb < 0)) q = -q;
            return {1'b0, q[31:0]};
         end
         default: begin
            if (sa < 0) return {1'b1, 32'h0};
            v    = sa * 65536;
            root = longint'($floor($sqrt(real'(v))));
            while (root * root > v) root--;
            while ((root + 1) * (root + 1) <= v) root++;
            return {1'b0, 8'h00, root[15:0], 8'h00};
         end
      endcase
   endfunction

   task automatic startOp(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      hostWrite(3'd0, a[15:8]);
      hostWrite(3'd1, a[7:0]);
      hostWrite(3'd2, b[15:8]);
      hostWrite(3'd3, b[7:0]);
      hostWrite(3'd7, {6'($urandom), op});
   endtask

   task automatic runCheck(input string tag, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] expX, input logic expErr);
      logic [7:0] st, b0, b1, b2, b3;
      startOp(op, a, b);
      hostRead(3'd4, st);
      check({tag, "_busy"}, {31'd0, st[0]}, 32'd1);
      repeat (40) waitDrive();
      check({tag, "_x"}, dut.X, expX);
      hostRead(3'd4, st);
      check({tag, "_status"}, {24'd0, st}, {30'd0, expErr, 1'b0});
      hostRead(3'd0, b0);
      hostRead(3'd1, b1);
      hostRead(3'd2, b2);
      hostRead(3'd3, b3);
      check({tag, "_xbus"}, {b0, b1, b2, b3}, expX);
   endtask

   function automatic logic [15:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected TB_RESULT");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  st;
      logic [1:0]  op;
      logic [15:0] a, b;
      logic [32:0] exp;

      hostIf.readBus    = 1'b1;
      hostIf.writeBus   = 1'b1;
      hostIf.addressBus = 3'd0;
      hostDrive         = 1'b1;
      hostData          = 8'h5A;
      reset             = 1'b1;
      repeat (3) waitDrive();

      // Bus released by the DUT during reset.
      #0.3;
      check("hiz_reset_5a", {24'd0, dataBus}, 32'h5A);
      hostData = 8'hA5;
      #0.3;
      check("hiz_reset_a5", {24'd0, dataBus}, 32'hA5);

      // Data stays on the bus across reset release with the strobe high: no write.
      hostData = 8'h5A;
      waitDrive();
      reset = 1'b0;
      repeat (4) waitDrive();
      hostDrive = 1'b0;
      check("reset_a", dut.A, 32'h0);
      check("reset_b", dut.B, 32'h0);
      check("reset_x", dut.X, 32'h0);
      hostRead(3'd4, st);
      check("reset_status", {24'd0, st}, 32'h0);

      // Byte writes observed 2.5 cycles after the strobe rises.
      hostWrite(3'd0, 8'hAA);
      #3;
      check("wr_a_hi", dut.A, 32'hAA00);
      hostWrite(3'd1, 8'hAA);
      #3;
      check("wr_a_lo", dut.A, 32'hAAAA);
      hostWrite(3'd2, 8'h55);
      #3;
      check("wr_b_hi", dut.B, 32'h5500);
      hostWrite(3'd4, 8'h11);
      hostWrite(3'd5, 8'h22);
      hostWrite(3'd6, 8'h33);
      check("wr_ignored_a", dut.A, 32'hAAAA);
      check("wr_ignored_b", dut.B, 32'h5500);

      foreach (vecs[i])
         runCheck($sformatf("dir%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].err);

      // Readback of a known result, unused addresses, and bus release.
      runCheck("ffaa", 2'd2, 16'hFFAA, 16'h0001, 32'hFFAA0000, 1'b0);
      hostRead(3'd0, st);
      check("rd_addr0", {24'd0, st}, 32'hFF);
      hostRead(3'd1, st);
      check("rd_addr1", {24'd0, st}, 32'hAA);
      hostRead(3'd5, st);
      check("rd_addr5", {24'd0, st}, 32'h00);
      hostRead(3'd6, st);
      check("rd_addr6", {24'd0, st}, 32'h00);
      hostRead(3'd7, st);
      check("rd_addr7", {24'd0, st}, 32'h00);
      waitDrive();
      hostIf.addressBus = 3'd0;
      hostDrive         = 1'b1;
      hostData          = 8'h5A;
      #0.5;
      check("hiz_idle_5a", {24'd0, dataBus}, 32'h5A);
      hostData = 8'hA5;
      #0.3;
      check("hiz_idle_a5", {24'd0, dataBus}, 32'hA5);
      hostDrive = 1'b0;

      // Busy behaviour: X held, opcode ignored, operand writes land without disturbing the run.
      startOp(2'd1, 16'd100, 16'd7);
      hostRead(3'd4, st);
      check("run_status", {24'd0, st}, 32'h01);
      hostRead(3'd0, st);
      check("run_x_hold", {24'd0, st}, 32'hFF);
      hostWrite(3'd7, 8'h00);
      hostWrite(3'd0, 8'h12);
      #3;
      check("run_a_write", dut.A, 32'h1264);
      repeat (40) waitDrive();
      check("run_result", dut.X, 32'h000E0002);
      hostRead(3'd4, st);
      check("run_done_status", {24'd0, st}, 32'h00);

      // Error flag persists until the next accepted opcode.
      runCheck("div0", 2'd1, 16'h0001, 16'h0000, 32'h0, 1'b1);
      hostWrite(3'd0, 8'h00);
      hostRead(3'd4, st);
      check("err_persist", {24'd0, st}, 32'h02);
      runCheck("err_clear", 2'd0, 16'h0002, 16'h0003, 32'h6, 1'b0);

      // Reset in the middle of an operation aborts it.
      startOp(2'd2, 16'h7FFF, 16'h0003);
      repeat (5) waitDrive();
      reset = 1'b1;
      repeat (2) waitDrive();
      reset = 1'b0;
      check("abort_x", dut.X, 32'h0);
      repeat (40) waitDrive();
      check("abort_x_late", dut.X, 32'h0);
      check("abort_a", dut.A, 32'h0);
      hostRead(3'd4, st);
      check("abort_status", {24'd0, st}, 32'h00);

      for (int i = 0; i < 24; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = pickOperand();
         b   = pickOperand();
         exp = refModel(op, a, b);
         runCheck($sformatf("rnd%0d_op%0d_%04h_%04h", i, op, a, b), op, a, b, exp[31:0], exp[32]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/top_v1.md
TOP_V1 -- requirements
Module: top_v1

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port: readBus  input  1  active-low read strobe from the host.
REQ-004 SHALL have port: writeBus  input  1  active-low write strobe from the host.
REQ-005 SHALL have port: addressBus  input  3  register address.
REQ-006 SHALL have port: dataBus  inout  8  bidirectional host data bus.
REQ-007 SHALL expose these internal registers by hierarchical name for verification:
- A[15:0] and B[15:0]: signed operands.
- X[31:0]: result.

Function
REQ-008 SHALL sample writeBus, addressBus and dataBus on every clk edge.
REQ-009 A write event SHALL be the cycle where the previous writeBus sample is 0 and the current sample is 1.
REQ-010 On a write event, the target register SHALL update within 2 clk cycles of the strobe rising, using the address and data captured in that same cycle.
REQ-011 Write map:
- 0 = A[15:8]
- 1 = A[7:0]
- 2 = B[15:8]
- 3 = B[7:0]
- 7 = opcode; this write starts the operation.
- Addresses 4 to 6: writes are ignored.
- Host address 15 truncates to 7.
REQ-012 Opcodes (low 2 bits used; bits 7:2 ignored):
- 0 = MULT
- 1 = DIVMOD
- 2 = DIVFRACT
- 3 = SQRT
REQ-013 While readBus is 0, the block SHALL drive dataBus combinationally; otherwise dataBus SHALL be high-Z.
REQ-014 Read map:
- 0 = X[31:24], 1 = X[23:16], 2 = X[15:8], 3 = X[7:0].
- 4 = status: bit0 busy, bit1 error, bits 7:2 zero.
- 5 to 7 read 0x00.
REQ-015 Operations SHALL be multi-cycle, controlled by an FSM with states IDLE, RUN, DONE.
- An opcode write in IDLE: latch operands, clear error, set busy, go to RUN.
- RUN: iterative shift/add or shift/subtract, at most one bit per cycle.
- DONE: load X, clear busy, return to IDLE.
REQ-016 X SHALL be valid no later than 48 clk cycles after the opcode write event.
REQ-017 X SHALL hold its value until the next operation completes.
REQ-018 An opcode write while busy SHALL be ignored.
REQ-019 A/B writes while busy SHALL update A/B without affecting the operation in progress.
REQ-020 MULT: X = A*B, signed 16x16 giving a 32-bit result.
- If either operand is 0x8000: X = 0 and error = 1.
- Examples: 0x8001*0x8001 = 0x3FFF0001; 0xFFF0*0xFFFF = 0x00000010; 0x0001*0xFFFF = 0xFFFFFFFF.
REQ-021 DIVMOD:
- X[31:16] = A/B, signed, truncated toward zero.
- X[15:0] = remainder, with the sign of A.
- Example: 0xFD00/0xFF00 = 0x00030000.
REQ-022 DIVFRACT: X = signed Q16.16 of A/B, computed as |A|*2^16 / |B| truncated, then negated if the signs of A and B differ.
- Example: 0x7FFF/0x0003 = 0x2AAA5555.
REQ-023 SQRT:
- X[23:8] = floor(sqrt(A*2^16)), i.e. an 8.8 result.
- X[31:24] = 0 and X[7:0] = 0.
- B is ignored.
- Example: sqrt(0x7FFF) = 0x00B50400.
REQ-024 Divide by zero (DIVMOD, DIVFRACT) SHALL give X = 0 and error = 1.
REQ-025 SQRT with negative A SHALL give X = 0 and error = 1.
REQ-026 The error bit SHALL persist until the next accepted opcode.

Reset
REQ-027 When reset = 1 at a clk edge, the block SHALL:
- set A, B, X, busy and error to 0;
- set the FSM to IDLE;
- clear the captured strobe history so no false write event is detected.
REQ-028 Reset mid-operation SHALL abort the operation; X SHALL remain 0.
REQ-029 While readBus = 1, dataBus SHALL be high-Z, including during reset.

Verification
REQ-030 Write 0xAA to addr 0, then 0xAA to addr 1, then 0x55 to addr 2 -> A = 0xAA00, then A = 0xAAAA, then B = 0x5500; each value is checked 5 ns (2.5 cycles) after its write strobe rises.
REQ-031 MULT: 0x7FFF*0x7FFF -> X = 0x3FFF0001.
- 0x8000*0x8000 -> X = 0 with error = 1.
- 0x7FFF*0x0000 -> X = 0.
REQ-032 DIVMOD:
- 0xFFF0/0x0003 -> X = 0xFFFBFFFF.
- 0x7FFE/0x7FFF -> X = 0x00007FFE.
- 0x0001/0x0000 -> X = 0 with error = 1.
REQ-033 DIVFRACT:
- 0x0003/0x0002 -> X = 0x00018000.
- 0x000A/0x0003 -> X = 0x00035555.
- 0x0001/0x0004 -> X = 0x00004000.
REQ-034 SQRT: A = 4 -> X = 0x00020000; A = 100 -> X = 0x000A0000; A = 2 -> X = 0x00016A00.
REQ-035 After X = 0xFFAA0000, the bench SHALL:
- read addr 0 and get 0xFF; read addr 1 and get 0xAA;
- read addr 4 during RUN and get bit0 = 1;
- check dataBus is high-Z while readBus = 1.
